// File: rtl/sp_types_pkg.sv
// Shared types for the scratchpad bank arbiter.
//   WORD_W       : bank address width
//   BITS_PER_ROW : bank row (data) width
//   wFIFO_t      : {addr, data} entry pushed into the write FIFO
//   rFIFO_t      : {addr} entry pushed into the read-request FIFO
//   arb_state_e  : arbiter FSM state; the encoding is exported on 'owner'
package sp_types_pkg;

    localparam int WORD_W       = 8;
    localparam int BITS_PER_ROW = 32;

    typedef struct packed {
        logic [WORD_W-1:0]       addr;
        logic [BITS_PER_ROW-1:0] data;
    } wFIFO_t;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
    } rFIFO_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SERVE_INSTR = 2'd1,
        SERVE_PSUM  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sp_bank_arbiter.sv
// Two-requester arbiter in front of a scratchpad bank's write / read-request
// FIFOs. The instruction path may read or write; the psum writeback path
// always writes. Grants and FIFO pushes are combinational in the accepting
// cycle. A burst counter bounds consecutive grants to one owner while the
// other requester is eligible; psum_urgent overrides everything.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   instr_req/wr/addr/wdata   instruction-path request
//   psum_req/addr/wdata       psum writeback request (write only)
//   psum_urgent               psum FIFO full: psum takes absolute priority
//   wFIFO_full, rFIFO_full    target FIFO back-pressure
//   instr_gnt, psum_gnt       request accepted this cycle (one-hot or zero)
//   wFIFO_WEN/wFIFO_wdata     write-FIFO push {addr, data}
//   rFIFO_WEN/rFIFO_wdata     read-FIFO push {addr}
//   owner                     current FSM state encoding (debug)
module sp_bank_arbiter
    import sp_types_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    instr_req,
    input  logic                    instr_wr,
    input  logic [WORD_W-1:0]       instr_addr,
    input  logic [BITS_PER_ROW-1:0] instr_wdata,
    input  logic                    psum_req,
    input  logic [WORD_W-1:0]       psum_addr,
    input  logic [BITS_PER_ROW-1:0] psum_wdata,
    input  logic                    psum_urgent,
    input  logic                    wFIFO_full,
    input  logic                    rFIFO_full,
    output logic                    instr_gnt,
    output logic                    psum_gnt,
    output logic                    wFIFO_WEN,
    output wFIFO_t                  wFIFO_wdata,
    output logic                    rFIFO_WEN,
    output rFIFO_t                  rFIFO_wdata,
    output logic [1:0]              owner
);

    localparam int                CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic instr_elig;
    logic psum_elig;
    logic gnt_i;
    logic gnt_p;
    logic under_limit;

    // A request only counts if the FIFO it would push into has room.
    assign instr_elig  = instr_req & (instr_wr ? ~wFIFO_full : ~rFIFO_full);
    assign psum_elig   = psum_req & ~wFIFO_full;
    assign under_limit = (burst_cnt_q < CNT_MAX);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state and burst counter
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (gnt_i) begin
            state_d     = SERVE_INSTR;
            burst_cnt_d = (state_q != SERVE_INSTR) ? CNT_ONE :
                          (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CNT_ONE;
        end else if (gnt_p) begin
            state_d     = SERVE_PSUM;
            burst_cnt_d = (state_q != SERVE_PSUM) ? CNT_ONE :
                          (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CNT_ONE;
        end else if (!instr_req && !psum_req) begin
            state_d = IDLE;
        end
    end

    // Grant selection and FIFO pushes
    always_comb begin
        gnt_i       = 1'b0;
        gnt_p       = 1'b0;
        wFIFO_WEN   = 1'b0;
        wFIFO_wdata = '0;
        rFIFO_WEN   = 1'b0;
        rFIFO_wdata = '0;
        owner       = 2'(state_q);

        if (RST) begin
            owner = 2'(IDLE);
        end else begin
            if (psum_urgent && psum_elig) begin
                gnt_p = 1'b1;
            end else begin
                // Owner keeps the bank while under its burst limit; past the
                // limit it yields to an eligible peer, otherwise it continues.
                unique case (state_q)
                    SERVE_INSTR: begin
                        if (instr_elig && under_limit) gnt_i = 1'b1;
                        else if (psum_elig)             gnt_p = 1'b1;
                        else if (instr_elig)            gnt_i = 1'b1;
                    end
                    SERVE_PSUM: begin
                        if (psum_elig && under_limit)   gnt_p = 1'b1;
                        else if (instr_elig)            gnt_i = 1'b1;
                        else if (psum_elig)             gnt_p = 1'b1;
                    end
                    default: begin
                        if (instr_elig)      gnt_i = 1'b1;
                        else if (psum_elig)  gnt_p = 1'b1;
                    end
                endcase
            end

            if (gnt_p) begin
                wFIFO_WEN        = 1'b1;
                wFIFO_wdata.addr = psum_addr;
                wFIFO_wdata.data = psum_wdata;
            end else if (gnt_i && instr_wr) begin
                wFIFO_WEN        = 1'b1;
                wFIFO_wdata.addr = instr_addr;
                wFIFO_wdata.data = instr_wdata;
            end else if (gnt_i) begin
                rFIFO_WEN        = 1'b1;
                rFIFO_wdata.addr = instr_addr;
            end
        end
    end

    assign instr_gnt = gnt_i;
    assign psum_gnt  = gnt_p;

endmodule

// File: doc/sp_bank_arbiter.md
SP_BANK_ARBITER -- requirements
Module: sp_bank_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4: max consecutive grants to one requester while the other is waiting.
REQ-002 SHALL have ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- instr_req  in  1  instruction-path request valid.
- instr_wr  in  1  1 = write to bank, 0 = read from bank.
- instr_addr  in  WORD_W  instruction-path bank address.
- instr_wdata  in  BITS_PER_ROW  instruction-path write data.
- psum_req  in  1  psum-out writeback request valid; always a write.
- psum_addr  in  WORD_W  psum writeback address.
- psum_wdata  in  BITS_PER_ROW  psum writeback data.
- psum_urgent  in  1  psumoutFIFO full; psum path gets absolute priority.
- wFIFO_full  in  1  write FIFO full.
- rFIFO_full  in  1  read-request FIFO full.
- instr_gnt  out  1  instruction request accepted this cycle.
- psum_gnt  out  1  psum request accepted this cycle.
- wFIFO_WEN  out  1  write-FIFO push.
- wFIFO_wdata  out  wFIFO_t  {addr, data} pushed.
- rFIFO_WEN  out  1  read-FIFO push.
- rFIFO_wdata  out  rFIFO_t  {addr} pushed.
- owner  out  2  current state encoding (debug).

Function
REQ-003 SHALL implement FSM states IDLE, SERVE_INSTR, SERVE_PSUM.
REQ-004 A request SHALL be eligible only when its target FIFO is not full: instr write needs !wFIFO_full; instr read needs !rFIFO_full; psum needs !wFIFO_full.
REQ-005 At most one grant SHALL be asserted per cycle; instr_gnt and psum_gnt are never both 1.
REQ-006 Grants and FIFO pushes SHALL be combinational in the accepting cycle (zero latency); requester holds req/addr/data stable until its grant.
REQ-007 On grant: wFIFO_WEN=1 with the granted addr/data for writes; rFIFO_WEN=1 with instr_addr for instr reads; the other WEN is 0.
REQ-008 Priority order SHALL be: psum_urgent & psum eligible -> psum; else the current owner, if eligible and burst_cnt < BURST_MAX; else the other requester, if eligible; else the current owner, if eligible.
REQ-009 In IDLE with both eligible and no urgent, instr SHALL win (tie-break).
REQ-010 burst_cnt SHALL reset to 1 on a grant that changes owner, increment on a same-owner grant (saturating at BURST_MAX), and hold when there is no grant.
REQ-011 The burst limit SHALL apply only if the other requester is eligible; a lone requester is granted every cycle without limit.
REQ-012 Next state SHALL be SERVE_X after a grant to X; IDLE after a cycle with no request asserted; otherwise the state holds.
REQ-013 An ineligible request because its FIFO is full SHALL NOT be granted; the other eligible request is granted and burst_cnt is unaffected by the blocked one.
REQ-014 psum_urgent SHALL override the burst limit; urgent psum grants still count toward burst_cnt.
REQ-015 owner encoding: IDLE=0, SERVE_INSTR=1, SERVE_PSUM=2.

Reset
REQ-016 When RST=1 at a CLK edge, the FSM SHALL go to IDLE and burst_cnt to 0.
REQ-017 While RST=1, all grant and WEN outputs SHALL be 0 and wdata outputs 0, regardless of requests; reset mid-burst discards burst history.

Structure
REQ-018 wFIFO_t, rFIFO_t, WORD_W, BITS_PER_ROW and the FSM state enum SHALL live in sp_types_pkg.
REQ-019 No sub-module is required; burst counter and FSM are inline.

Verification
REQ-020 Reset: RST=1 with both reqs high -> all gnt/WEN 0, owner=0; first cycle after release with both eligible -> instr_gnt=1, owner=1 next cycle.
REQ-021 Fairness: both requesting continuously, no full, BURST_MAX=4 -> grant pattern I,I,I,I,P,P,P,P,I...
REQ-022 Urgent: instr mid-burst (cnt=2), psum_urgent=1 -> psum_gnt=1 same cycle; urgent held for 6 cycles -> 6 consecutive psum grants.
REQ-023 Full: instr read with rFIFO_full=1 and psum pending -> psum granted every cycle; rFIFO_full drops -> instr granted within BURST_MAX+1 cycles.
REQ-024 Lone requester: only psum_req for 10 cycles -> 10 grants, wFIFO_WEN=1 each cycle with matching addr/data.
REQ-025 Read path: instr_wr=0, addr=0x1A -> rFIFO_WEN=1, rFIFO_wdata.addr=0x1A, wFIFO_WEN=0.
